uart_rx_core: RTL and testbench
===============================

// Module: uart_rx_core
// PURPOSE
//  Parametrised next-generation UART receiver: configurable oversampling, run-time baud
//  divisor, data length 5-8 bits, none/odd/even parity, 1 or 2 stop bits.
//  Majority-vote bit sampling; separate parity/frame/overrun flags.
//  Holding register with valid/ready handshake toward the host or RX FIFO.
//  Sits between the pad (after nothing: synchroniser included) and the UART register block.
// PARAMETERS
//  OVS    16  oversample ticks per bit; even, >=8
//  DIV_W  16  width of baud_div
// PORTS
//  clk          in   1      system clock
//  rst          in   1      async active-high reset
//  din          in   1      serial line, idle high, asynchronous to clk
//  baud_div     in   DIV_W  clocks per oversample tick minus 1 (0 = tick every clk)
//  dlen         in   2      00=5, 01=6, 10=7, 11=8 data bits
//  par          in   2      00/11=none, 01=odd, 10=even
//  snum         in   1      0=1 stop bit, 1=2 stop bits
//  rx_data      out  8      received word, LSB first on line, zero-extended above dlen
//  rx_valid     out  1      rx_data and flags valid
//  rx_ready     in   1      consumer accepts when rx_valid&rx_ready
//  parity_err   out  1      parity mismatch for word in rx_data
//  frame_err    out  1      a stop bit sampled 0 for word in rx_data
//  overrun_err  out  1      sticky: >=1 frame dropped because holding reg was full
//  busy         out  1      FSM not in IDLE
// BEHAVIOUR
//  Synchroniser: 2 flops on din, reset to 1. All logic uses synced din (ds).
//  Reset: rx_data=0, rx_valid=0, all err=0, busy=0, FSM=IDLE, counters=0.
//  Reset mid-frame: the frame is discarded.
//  Tick gen: cnt counts 0..baud_div; tick when cnt==baud_div, then cnt wraps to 0.
//  It free-runs; a baud_div change takes effect at the next wrap.
//  dlen/par/snum are latched on the IDLE->START transition; mid-frame changes are ignored.
//  Per-state tick counter s: 0..OVS-1, cleared on every state change.
//  Bit decision (DATA/PARITY/STOP*): fires at tick with s==OVS-1.
//  Decided value = majority of ds at the ticks s=OVS-3, OVS-2, OVS-1.
//  FSM states:
//   IDLE  : ds==0 on a tick -> START.
//   START : at s==OVS/2-1: ds==1 -> IDLE (glitch, no flags, no output); else -> DATA.
//   DATA  : shift decided bit into bit OF the data reg; after N=dlen+5 bits
//           -> PARITY if par is 01/10, else STOP1.
//   PARITY: odd: ok iff ^{data[N-1:0],p}==1. even: ok iff ==0. -> STOP1.
//   STOP1 : decided 0 sets frame error. 2-stop mode with bit 1 -> STOP2; else commit.
//   STOP2 : decided 0 sets frame error; commit.
//   After commit: frame error -> BRK (wait until ds==1 on a tick, then IDLE); else IDLE.
//   BRK   : busy stays 1.
//  Commit (clk after the final stop decision tick):
//   - holding free (rx_valid==0, or rx_valid&rx_ready this cycle): load rx_data,
//     parity_err, frame_err; rx_valid<=1.
//   - else: drop the frame; rx_data and flags keep the old word; overrun_err<=1.
//  Handshake: rx_valid&rx_ready on a clk -> rx_valid, parity_err, frame_err, overrun_err <= 0.
//  A commit in the same cycle as the handshake wins: new word valid, overrun_err=0.
//  rx_valid stays high and outputs stay stable until accepted.
//  Width: bits of rx_data above N are 0. Errors never block data delivery.
// TESTING  (baud_div=3, OVS=16 -> 64 clk/bit)
//  1. 8N1 frame 0xA5, rx_ready=0 -> rx_valid=1, rx_data=0xA5, no err, held; rx_ready=1 -> rx_valid=0.
//  2. 7E1 frame 0x35 with parity bit 1 (correct is 0) -> rx_data=0x35, parity_err=1, frame_err=0.
//  3. 8N1 0x3C, stop bit 0, line held low 200 clk -> frame_err=1, busy=1 until din high.
//  4. 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11, overrun_err=1; accept -> all clear.
//  5. din low 24 clk (6 ticks < OVS/2) -> no rx_valid, busy returns 0; single-tick glitch
//     mid data bit -> majority keeps the correct bit.
//  6. 5O2 0x15, 2nd stop=0 -> rx_data=0x15, frame_err=1; rst mid-frame -> all outputs 0.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with run-time baud divisor,
// 5-8 data bits, optional odd/even parity and 1 or 2 stop bits.
// Bits are decided by a 3-sample majority vote. The received word waits in a
// holding register with a valid/ready handshake. Parity, frame and overrun
// errors are flagged separately; an error never blocks delivery of the word.
module uart_rx_core #(
    parameter int OVS   = 16,
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [DIV_W-1:0] baud_div,
    input  logic [1:0]       dlen,
    input  logic [1:0]       par,
    input  logic             snum,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             parity_err,
    output logic             frame_err,
    output logic             overrun_err,
    output logic             busy
);

    localparam int SW = $clog2(OVS);
    localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
    localparam logic [SW-1:0] S_MID2 = SW'(OVS - 2);
    localparam logic [SW-1:0] S_MID3 = SW'(OVS - 3);
    localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5,
        BRK    = 3'd6
    } state_t;

    state_t             state_reg, state_next;
    logic               sync1_reg, ds_reg;
    logic [DIV_W-1:0]   cnt_reg, div_reg;
    logic [SW-1:0]      s_reg;
    logic               v0_reg, v1_reg;
    logic [2:0]         bit_cnt_reg;
    logic [7:0]         shift_reg;
    logic [1:0]         dlen_reg, par_reg;
    logic               snum_reg;
    logic               perr_acc_reg, ferr_acc_reg;
    logic               commit_reg, commit_next;

    logic               tick;
    logic               decide;
    logic               maj;
    logic               par_en;
    logic [2:0]         last_bit;
    logic               handshake;

    assign tick      = (cnt_reg == div_reg);
    assign decide    = tick && (s_reg == S_LAST);
    assign maj       = (v0_reg & v1_reg) | (v0_reg & ds_reg) | (v1_reg & ds_reg);
    assign par_en    = par_reg[0] ^ par_reg[1];
    assign last_bit  = {1'b0, dlen_reg} + 3'd4;
    assign handshake = rx_valid & rx_ready;
    assign busy      = (state_reg != IDLE);

    // Two-flop synchroniser on the asynchronous line; idles high out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= 1'b1;
            ds_reg    <= 1'b1;
        end else begin
            sync1_reg <= din;
            ds_reg    <= sync1_reg;
        end
    end

    // Free-running oversample tick; a new divisor is picked up only at the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            div_reg <= '0;
        end else if (cnt_reg == div_reg) begin
            cnt_reg <= '0;
            div_reg <= baud_div;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

    // Next-state logic; a commit pulse is raised on the final stop decision
    always_comb begin
        state_next  = state_reg;
        commit_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tick && !ds_reg)
                    state_next = START;
            end
            START: begin
                if (tick && (s_reg == S_HALF))
                    state_next = ds_reg ? IDLE : DATA;
            end
            DATA: begin
                if (decide && (bit_cnt_reg == last_bit))
                    state_next = par_en ? PARITY : STOP1;
            end
            PARITY: begin
                if (decide)
                    state_next = STOP1;
            end
            STOP1: begin
                if (decide) begin
                    if (snum_reg && maj) begin
                        state_next = STOP2;
                    end else begin
                        commit_next = 1'b1;
                        state_next  = (ferr_acc_reg || !maj) ? BRK : IDLE;
                    end
                end
            end
            STOP2: begin
                if (decide) begin
                    commit_next = 1'b1;
                    state_next  = (ferr_acc_reg || !maj) ? BRK : IDLE;
                end
            end
            BRK: begin
                if (tick && ds_reg)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, per-state tick counter, vote samples and frame assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            commit_reg   <= 1'b0;
            s_reg        <= '0;
            v0_reg       <= 1'b1;
            v1_reg       <= 1'b1;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            dlen_reg     <= '0;
            par_reg      <= '0;
            snum_reg     <= 1'b0;
            perr_acc_reg <= 1'b0;
            ferr_acc_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            commit_reg <= commit_next;

            if (state_next != state_reg)
                s_reg <= '0;
            else if (tick)
                s_reg <= (s_reg == S_LAST) ? '0 : s_reg + SW'(1);

            if (tick && (s_reg == S_MID3))
                v0_reg <= ds_reg;
            if (tick && (s_reg == S_MID2))
                v1_reg <= ds_reg;

            // Frame format is frozen for the whole frame at start detection
            if ((state_reg == IDLE) && (state_next == START)) begin
                dlen_reg     <= dlen;
                par_reg      <= par;
                snum_reg     <= snum;
                shift_reg    <= '0;
                bit_cnt_reg  <= '0;
                perr_acc_reg <= 1'b0;
                ferr_acc_reg <= 1'b0;
            end

            if ((state_reg == DATA) && decide) begin
                shift_reg[bit_cnt_reg] <= maj;
                bit_cnt_reg            <= bit_cnt_reg + 3'd1;
            end

            // Unused upper data bits are zero, so a full-width XOR is exact
            if ((state_reg == PARITY) && decide)
                perr_acc_reg <= (par_reg == 2'b01) ? ~(^shift_reg ^ maj)
                                                   :  (^shift_reg ^ maj);

            if (((state_reg == STOP1) || (state_reg == STOP2)) && decide && !maj)
                ferr_acc_reg <= 1'b1;
        end
    end

    // Holding register: commit beats a same-cycle accept; a full register drops the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else if (commit_reg) begin
            if (!rx_valid || rx_ready) begin
                rx_data     <= shift_reg;
                parity_err  <= perr_acc_reg;
                frame_err   <= ferr_acc_reg;
                rx_valid    <= 1'b1;
                overrun_err <= 1'b0;
            end else begin
                overrun_err <= 1'b1;
            end
        end else if (handshake) begin
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Testbench for uart_rx_core: directed serial frames at 64 clk/bit, expected
// words queued by the stimulus and checked by a monitor on each handshake.
module tb_uart_rx_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        din;
    logic [15:0] baud_div;
    logic [1:0]  dlen;
    logic [1:0]  par;
    logic        snum;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        parity_err;
    logic        frame_err;
    logic        overrun_err;
    logic        busy;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    uart_rx_core #(.OVS(16), .DIV_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .baud_div    (baud_div),
        .dlen        (dlen),
        .par         (par),
        .snum        (snum),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Drive the line to v for n clocks; always returns 1 time unit after an edge
    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input int n, input bit has_par,
                        input logic pbit, input int nstop, input logic s1, input logic s2);
        hold(1'b0, 64);
        for (int i = 0; i < n; i++)
            hold(d[i], 64);
        if (has_par)
            hold(pbit, 64);
        hold(s1, 64);
        if (nstop == 2)
            hold(s2, 64);
    endtask

    // Monitor: every accepted word is compared with the head of the queue
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got rx_data=0x%0h expected no word", rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("rx word data=0x%02h pe=%0d fe=%0d ov=%0d (expected 0x%02h %0d %0d %0d)",
                         rx_data, parity_err, frame_err, overrun_err,
                         mon_e.d, mon_e.pe, mon_e.fe, mon_e.ov);
                chk("rx_data", {24'd0, rx_data}, {24'd0, mon_e.d});
                chk("parity_err", {31'd0, parity_err}, {31'd0, mon_e.pe});
                chk("frame_err", {31'd0, frame_err}, {31'd0, mon_e.fe});
                chk("overrun_err", {31'd0, overrun_err}, {31'd0, mon_e.ov});
            end
        end
    end

    initial begin
        rst      = 1'b1;
        din      = 1'b1;
        rx_ready = 1'b0;
        baud_div = 16'd3;
        dlen     = 2'b11;
        par      = 2'b00;
        snum     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_errs", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
        rst = 1'b0;
        hold(1'b1, 40);

        // 1: 8N1 0xA5, held while not ready, then accepted
        exp_q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        send(8'hA5, 8, 0, 1'b0, 1, 1'b1, 1'b0);
        hold(1'b1, 64);
        chk("t1_valid", {31'd0, rx_valid}, 32'd1);
        chk("t1_data", {24'd0, rx_data}, 32'hA5);
        hold(1'b1, 64);
        chk("t1_held_valid", {31'd0, rx_valid}, 32'd1);
        chk("t1_held_data", {24'd0, rx_data}, 32'hA5);
        rx_ready = 1'b1;
        hold(1'b1, 4);
        chk("t1_accepted", {31'd0, rx_valid}, 32'd0);

        // 2: 7E1 0x35 with wrong parity bit
        dlen = 2'b10;
        par  = 2'b10;
        exp_q.push_back('{d: 8'h35, pe: 1'b1, fe: 1'b0, ov: 1'b0});
        send(8'h35, 7, 1, 1'b1, 1, 1'b1, 1'b0);
        hold(1'b1, 64);

        // 3: 8N1 0x3C with stop bit 0 and line held low -> break
        dlen = 2'b11;
        par  = 2'b00;
        exp_q.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b1, ov: 1'b0});
        send(8'h3C, 8, 0, 1'b0, 1, 1'b0, 1'b0);
        hold(1'b0, 200);
        chk("t3_busy_in_break", {31'd0, busy}, 32'd1);
        chk("t3_word_taken", {31'd0, rx_valid}, 32'd0);
        hold(1'b1, 20);
        chk("t3_busy_released", {31'd0, busy}, 32'd0);
        hold(1'b1, 64);

        // 4: two back-to-back frames while not ready -> second dropped, overrun
        rx_ready = 1'b0;
        exp_q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0, ov: 1'b1});
        send(8'h11, 8, 0, 1'b0, 1, 1'b1, 1'b0);
        send(8'h22, 8, 0, 1'b0, 1, 1'b1, 1'b0);
        hold(1'b1, 64);
        chk("t4_overrun", {31'd0, overrun_err}, 32'd1);
        chk("t4_data_kept", {24'd0, rx_data}, 32'h11);
        rx_ready = 1'b1;
        hold(1'b1, 4);
        chk("t4_valid_clear", {31'd0, rx_valid}, 32'd0);
        chk("t4_overrun_clear", {31'd0, overrun_err}, 32'd0);

        // 5a: short low pulse rejected as a glitch
        hold(1'b0, 24);
        chk("t5_busy_glitch", {31'd0, busy}, 32'd1);
        hold(1'b1, 100);
        chk("t5_glitch_idle", {31'd0, busy}, 32'd0);
        chk("t5_glitch_no_word", {31'd0, rx_valid}, 32'd0);

        // 5b: 0x5A with one-tick glitches inside bits 2 and 3
        exp_q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0, ov: 1'b0});
        hold(1'b0, 64);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                hold(1'b0, 30); hold(1'b1, 4); hold(1'b0, 30);
            end else if (i == 3) begin
                hold(1'b1, 30); hold(1'b0, 4); hold(1'b1, 30);
            end else begin
                hold(((8'h5A >> i) & 8'h01) != 8'h00, 64);
            end
        end
        hold(1'b1, 64);
        hold(1'b1, 64);

        // 6: 5O2 0x15 with second stop bit 0
        dlen = 2'b00;
        par  = 2'b01;
        snum = 1'b1;
        exp_q.push_back('{d: 8'h15, pe: 1'b0, fe: 1'b1, ov: 1'b0});
        send(8'h15, 5, 1, 1'b0, 2, 1'b1, 1'b0);
        hold(1'b1, 64);
        chk("t6_idle_after_break", {31'd0, busy}, 32'd0);

        // 6b: word held, next frame interrupted by reset
        rx_ready = 1'b0;
        dlen = 2'b11;
        par  = 2'b00;
        snum = 1'b0;
        send(8'h77, 8, 0, 1'b0, 1, 1'b1, 1'b0);
        hold(1'b1, 32);
        chk("t6_word_held", {31'd0, rx_valid}, 32'd1);
        hold(1'b0, 64);
        hold(1'b1, 128);
        chk("t6_midframe_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #2;
        chk("t6_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("t6_rst_data", {24'd0, rx_data}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_errs", {29'd0, parity_err, frame_err, overrun_err}, 32'd0);
        hold(1'b1, 3);
        rst = 1'b0;
        hold(1'b1, 200);
        chk("t6_post_rst_valid", {31'd0, rx_valid}, 32'd0);
        chk("t6_post_rst_busy", {31'd0, busy}, 32'd0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
